booth_seq_mult: RTL

Sequential radix-4 Booth multiplier for unsigned WIDTH×WIDTH operands. It generates one Booth partial product per clock and folds it into a carry-save accumulator built from full_adder rows. A final carry-propagate pass produces the 2·WIDTH-bit product. It is the low-area counterpart of the parallel Wallace-tree path: it runs the partial-product side of the multiplier iteratively and sits behind a valid/ready stream interface.

---
 rtl/booth_pkg.sv | 29 ++
 rtl/booth_seq_mult_if.sv | 25 ++
 rtl/booth_encoder.sv | 23 ++
 rtl/full_adder.sv | 14 +
 rtl/booth_seq_mult.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Purpose: shared types and sizing helper for the sequential radix-4 Booth multiplier.
// Latency: n/a (types and a constant function only).
// Backpressure: n/a.
// Contents: state_t (controller states), digit_t (Booth digit), digits(width).
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    FIX,
    CPA,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } digit_t;

  // Number of radix-4 digits for an unsigned operand: one extra digit absorbs
  // the zero-extension so the top digit is never negative.
  function automatic int digits(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_seq_mult_if.sv
// Purpose: operand/product stream bundle for booth_seq_mult.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the product side.
// Ports: slave = multiplier side, master = producer/consumer side.
interface booth_seq_mult_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product
  );
endinterface

// File: rtl/booth_encoder.sv
// Purpose: radix-4 Booth recoder, one bit triplet to a signed digit.
// Latency: combinational.
// Backpressure: none.
// Ports: triplet_i {b[2i+1], b[2i], b[2i-1]}; digit_o recoded digit; neg_o digit is negative.
module booth_encoder
  import booth_pkg::*;
(
  input  logic [2:0] triplet_i,
  output digit_t     digit_o,
  output logic       neg_o
);
  always_comb begin
    digit_o = ZERO;
    case (triplet_i)
      3'b001, 3'b010: digit_o = POS1;
      3'b011:         digit_o = POS2;
      3'b100:         digit_o = NEG2;
      3'b101, 3'b110: digit_o = NEG1;
      default:        digit_o = ZERO;
    endcase
    neg_o = (digit_o == NEG1) || (digit_o == NEG2);
  end
endmodule

// File: rtl/full_adder.sv
// Purpose: single-bit full adder cell, used for both CSA rows and ripple CPA.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i, c_i addends; s_o sum; c_o carry out.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// File: rtl/booth_seq_mult.sv
// Purpose: sequential radix-4 Booth multiplier, unsigned WIDTH x WIDTH -> 2*WIDTH.
// Latency: out_valid rises DIGITS+2 edges after the accepting edge.
// Backpressure: in_ready only in IDLE; product held in DONE until out_ready.
// Ports: clk, rst_n (async active-low); bus (slave): in_valid/in_ready/in_a/in_b, out_valid/out_ready/out_product.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  booth_seq_mult_if.slave   bus
);
  localparam int DIGITS = digits(WIDTH);
  localparam int CW     = $clog2(DIGITS);
  localparam int PW     = 2 * WIDTH;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  // Multiplier with appended 0 LSB, shifted right by 2 per digit so the
  // current triplet always sits in bits [2:0].
  logic [WIDTH+2:0]  b_q, b_d;
  logic [PW-1:0]     sum_q, sum_d;
  logic [PW-1:0]     carry_q, carry_d;
  logic [PW-1:0]     corr_q, corr_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic              vld_q, vld_d;

  digit_t            digit;
  logic              neg;
  logic [WIDTH:0]    mag;
  logic [PW-1:0]     pp_base, pp, pp_lsb;
  logic [PW-1:0]     carry_sh, csa_in, csa_s, csa_c, cpa_s;

  booth_encoder u_enc (
    .triplet_i (b_q[2:0]),
    .digit_o   (digit),
    .neg_o     (neg)
  );

  // Partial product: invert before shifting so the vacated low bits stay 0;
  // the +1 of the two's complement then lands at weight 2^(2i) via corr.
  always_comb begin
    mag = '0;
    case (digit)
      POS1, NEG1: mag = {1'b0, a_q};
      POS2, NEG2: mag = {a_q, 1'b0};
      default:    mag = '0;
    endcase
    pp_base = {{(WIDTH-1){1'b0}}, mag};
    if (neg) pp_base = ~pp_base;
    pp     = pp_base << {cnt_q, 1'b0};
    pp_lsb = PW'(1) << {cnt_q, 1'b0};
  end

  assign carry_sh = {carry_q[PW-2:0], 1'b0};

  always_comb begin
    csa_in = '0;
    if (state_q == ACC)      csa_in = pp;
    else if (state_q == FIX) csa_in = corr_q;
  end

  // Carry-save row: one full adder per product bit.
  full_adder u_csa [PW-1:0] (
    .a_i (sum_q),
    .b_i (carry_sh),
    .c_i (csa_in),
    .s_o (csa_s),
    .c_o (csa_c)
  );

  // Ripple carry-propagate adder; per-bit carry nets keep the chain acyclic.
  for (genvar k = 0; k < PW; k++) begin : g_cpa
    logic ci;
    logic co;
    if (k == 0) begin : g_lsb
      assign ci = 1'b0;
    end else begin : g_rip
      assign ci = g_cpa[k-1].co;
    end
    full_adder u_fa (
      .a_i (sum_q[k]),
      .b_i (carry_sh[k]),
      .c_i (ci),
      .s_o (cpa_s[k]),
      .c_o (co)
    );
  end

  // Bits beyond 2^(2*WIDTH) are discarded by design (modulo arithmetic).
  logic unused_msb;
  assign unused_msb = carry_q[PW-1] ^ g_cpa[PW-1].co;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    corr_d  = corr_q;
    prod_d  = prod_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = {2'b00, bus.in_b, 1'b0};
          sum_d   = '0;
          carry_d = '0;
          corr_d  = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        sum_d   = csa_s;
        carry_d = csa_c;
        if (neg) corr_d = corr_q | pp_lsb;
        b_d = b_q >> 2;
        if (cnt_q == CW'(DIGITS - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        sum_d   = csa_s;
        carry_d = csa_c;
        state_d = CPA;
      end
      CPA: begin
        prod_d  = cpa_s;
        vld_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      corr_q  <= '0;
      prod_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      corr_q  <= corr_d;
      prod_q  <= prod_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = vld_q;
  assign bus.out_product = prod_q;

endmodule
